// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: owns the PC; fetches one instruction at a time over a valid/ready request
// and valid-only response channel, holds it for execute and advances the PC on commit.
module ifu_fetch_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc_next,
    input  logic            io_halt,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_inst_valid,
    input  logic            io_inst_ready,
    output logic [XLEN-1:0] io_instruction,
    output logic [XLEN-1:0] io_pc_count,
    output logic [31:0]     io_inst_count,
    output logic            io_halted,
    output logic            io_misaligned
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic [31:0]     cnt_q;
    logic            halted_q;
    logic            mis_q;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic            commit;
    logic            bad_pc;

    always_comb begin
        commit = (state_q == S_EXEC) && io_inst_ready;
        bad_pc = io_pc_next[1:0] != 2'b00;
    end

    // Valids are registered alongside each state transition so no input reaches an output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
            mis_q        <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
                S_REQ: begin
                    if (io_imem_req_ready) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (io_imem_resp_valid) begin
                        inst_q       <= io_imem_resp_data;
                        state_q      <= S_EXEC;
                        inst_valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        cnt_q        <= cnt_q + 32'd1;
                        inst_valid_q <= 1'b0;
                        if (io_halt || bad_pc) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            mis_q    <= !io_halt;
                        end else begin
                            pc_q        <= io_pc_next;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_imem_req_valid = req_valid_q;
    assign io_imem_req_addr  = pc_q;
    assign io_inst_valid     = inst_valid_q;
    assign io_instruction    = inst_q;
    assign io_pc_count       = pc_q;
    assign io_inst_count     = cnt_q;
    assign io_halted         = halted_q;
    assign io_misaligned     = mis_q;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: randomized episodes (reset, fetch/commit loop, halt or mid-fetch reset)
// with a program-level reference model feeding scoreboard queues that a monitor drains.
module tb_ifu_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; logic [31:0] cnt; } inst_e;
    typedef struct packed { logic mis; logic [31:0] pc; logic [31:0] cnt; } halt_e;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_pc_next = '0;
    logic        io_halt = 1'b0;
    logic        io_imem_req_ready = 1'b0;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = '0;
    logic        io_inst_ready = 1'b0;
    logic        io_imem_req_valid, io_inst_valid, io_halted, io_misaligned;
    logic [31:0] io_imem_req_addr, io_instruction, io_pc_count, io_inst_count;

    logic [31:0] exp_addr_q[$];
    inst_e       exp_inst_q[$];
    halt_e       exp_halt_q[$];
    logic [31:0] mem_q[$];
    int          mem_dly;
    logic [31:0] seed;
    int          total = 0;
    int          bad = 0;
    logic        prev_h = 1'b0;
    halt_e       h_last = '0;

    ifu_fetch_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .io_pc_next         (io_pc_next),
        .io_halt            (io_halt),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_instruction     (io_instruction),
        .io_pc_count        (io_pc_count),
        .io_inst_count      (io_inst_count),
        .io_halted          (io_halted),
        .io_misaligned      (io_misaligned)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the front of the scoreboard queues.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (io_imem_req_valid) begin
                chk("req_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) begin
                    chk("req_addr", io_imem_req_addr, exp_addr_q[0]);
                    chk("pc_at_req", io_pc_count, exp_addr_q[0]);
                    if (io_imem_req_ready) void'(exp_addr_q.pop_front());
                end
            end
            if (io_inst_valid) begin
                chk("inst_expected", 32'(exp_inst_q.size() > 0), 32'd1);
                if (exp_inst_q.size() > 0) begin
                    chk("instruction", io_instruction, exp_inst_q[0].ins);
                    chk("pc_at_exec", io_pc_count, exp_inst_q[0].pc);
                    chk("inst_count", io_inst_count, exp_inst_q[0].cnt);
                    if (io_inst_ready) void'(exp_inst_q.pop_front());
                end
            end
            if (io_halted && !prev_h) begin
                chk("halt_expected", 32'(exp_halt_q.size() > 0), 32'd1);
                if (exp_halt_q.size() > 0) h_last = exp_halt_q.pop_front();
            end
            if (io_halted) begin
                chk("halt_mis", 32'(io_misaligned), 32'(h_last.mis));
                chk("halt_pc", io_pc_count, h_last.pc);
                chk("halt_cnt", io_inst_count, h_last.cnt);
                chk("halt_req_valid", 32'(io_imem_req_valid), 32'd0);
                chk("halt_inst_valid", 32'(io_inst_valid), 32'd0);
            end
            prev_h = io_halted;
        end
    end

    task automatic episode();
        logic [31:0] m_pc, m_cnt, pn, p_addr;
        logic        m_done, p_hs, do_mid;
        int          reset_at, idle, post, sel;
        seed = $urandom;
        reset = 1'b1;
        io_imem_req_ready = 1'b0;
        io_inst_ready = 1'b0;
        exp_addr_q.delete();
        exp_inst_q.delete();
        exp_halt_q.delete();
        mem_q.delete();
        repeat (2) begin
            io_imem_resp_valid = ($urandom & 1) != 0;
            io_imem_resp_data = $urandom;
            @(negedge clock);
        end
        chk("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(io_inst_valid), 32'd0);
        chk("rst_pc", io_pc_count, RST_PC);
        chk("rst_instr", io_instruction, 32'd0);
        chk("rst_cnt", io_inst_count, 32'd0);
        chk("rst_halted", 32'(io_halted), 32'd0);
        chk("rst_mis", 32'(io_misaligned), 32'd0);
        m_pc = RST_PC;
        m_cnt = 0;
        m_done = 1'b0;
        exp_addr_q.push_back(m_pc);
        exp_inst_q.push_back('{m_pc, memf(m_pc), m_cnt});
        reset = 1'b0;
        io_imem_resp_valid = ($urandom & 1) != 0;
        p_hs = 1'b0;
        p_addr = '0;
        do_mid = ($urandom % 3) == 0;
        reset_at = $urandom_range(2, 40);
        idle = 0;
        post = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clock);
            if (p_hs) begin
                mem_q.push_back(p_addr);
                mem_dly = $urandom_range(0, 3);
            end
            if (do_mid && cyc >= reset_at && mem_q.size() > 0 && !io_imem_req_valid &&
                !io_inst_valid && !io_halted) return;
            if (m_done) begin
                post++;
                if (post > 5) begin
                    chk("halt_drained", 32'(exp_halt_q.size()), 32'd0);
                    return;
                end
            end else begin
                idle++;
                if (idle > 60) begin
                    total++;
                    bad++;
                    $display("FAIL progress: no commit for %0d cycles, expected pc %h", idle, m_pc);
                    return;
                end
            end
            io_imem_resp_valid = 1'b0;
            io_imem_resp_data = $urandom;
            if (mem_q.size() > 0) begin
                if (mem_dly == 0) begin
                    io_imem_resp_valid = 1'b1;
                    io_imem_resp_data = memf(mem_q.pop_front());
                end else mem_dly--;
            end else io_imem_resp_valid = ($urandom % 4) == 0;
            io_imem_req_ready = ($urandom % 3) != 0;
            p_hs = io_imem_req_valid && io_imem_req_ready;
            p_addr = io_imem_req_addr;
            io_inst_ready = ($urandom % 3) != 0;
            io_halt = ($urandom & 1) != 0;
            io_pc_next = $urandom;
            if (io_inst_valid && io_inst_ready) begin
                idle = 0;
                sel = $urandom_range(0, 15);
                pn = $urandom;
                pn[1:0] = 2'b00;
                io_halt = ($urandom % 16) == 0;
                if (sel == 0) begin
                    pn[1:0] = 2'($urandom_range(1, 3));
                    io_halt = ($urandom & 1) != 0;
                end else if (sel == 1) pn = m_pc;
                else if (sel == 2) pn = 32'hFFFF_FFFC;
                else if (sel == 3) pn = m_pc + 32'd4 == 32'd0 ? 32'd0 : 32'd0;
                else if (sel > 5) pn = m_pc + 32'd4;
                io_pc_next = pn;
                m_cnt = m_cnt + 32'd1;
                if (io_halt || pn[1:0] != 2'b00) begin
                    exp_halt_q.push_back('{!io_halt, m_pc, m_cnt});
                    m_done = 1'b1;
                end else begin
                    m_pc = pn;
                    exp_addr_q.push_back(m_pc);
                    exp_inst_q.push_back('{m_pc, memf(m_pc), m_cnt});
                end
            end
        end
    endtask

    initial begin
        @(negedge clock);
        for (int ep = 0; ep < 40; ep++) episode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
